uart_tx_frame_gen: RTL and testbench

Parametrised UART transmit frame generator. It accepts a parallel word on a valid/busy handshake and latches the word and the frame configuration. It computes the parity bit under one of four parity modes, then serialises a complete frame on TX_OUT at one bit per CLK: start bit, DATA_W data bits LSB-first, optional parity, and 1 or 2 stop bits. It sits in the UART TX path on the baud-rate clock domain, between the TX data FIFO read side and the serial pad. It replaces the fixed 8-bit separate parity/serializer pair.

---
 rtl/uart_tx_pkg.sv | 45 ++++
 rtl/uart_tx_frame_gen.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART TX/RX definitions: parity modes, TX FSM states, frame config and
// the parity helper shared with the RX checker.
package uart_tx_pkg;

  localparam int unsigned MAX_DATA_W = 9;
  localparam int unsigned MIN_DATA_W = 5;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Frame shape held for the frame in flight; the parity mode is fully
  // consumed into the parity bit at accept time.
  typedef struct packed {
    logic par_en;
    logic stop2;
  } tx_cfg_t;

  // Narrower words are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input par_mode_t mode);
    logic p;
    p = 1'b0;
    case (mode)
      PAR_EVEN:  p = ^data;
      PAR_ODD:   p = ~^data;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start, DATA_W data bits LSB-first, optional
// parity, 1 or 2 stop bits, one bit per CLK, with back-to-back frame support.
module uart_tx_frame_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic [1:0]        PAR_MODE,
  input  logic              STOP2,
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              PAR_BIT,
  output logic              DONE
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  tx_cfg_t           cfg_q,   cfg_d;
  logic              par_q,   par_d;
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              accept_c;

  // done_q marks the final stop cycle, which is also the back-to-back accept slot.
  assign accept_c = DATA_VALID && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && done_q));

  // Outputs are computed for the state being entered so that they are registered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      ST_START: begin
        state_d = ST_DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          if (cfg_q.par_en) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            done_d  = ~cfg_q.stop2;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
        done_d  = ~cfg_q.stop2;
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (accept_c) begin
      state_d = ST_START;
      shift_d = P_DATA;
      cfg_d   = '{par_en: PAR_EN, stop2: STOP2};
      par_d   = calc_parity(MAX_DATA_W'(P_DATA), par_mode_t'(PAR_MODE));
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign BUSY    = busy_q;
  assign PAR_BIT = par_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed self-checking bench for uart_tx_frame_gen (DATA_W=8 and DATA_W=5).
module tb_uart_tx_frame_gen;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_data;
  logic       a_valid, a_pe, a_s2;
  logic [1:0] a_mode;
  logic       a_tx, a_busy, a_par, a_done;

  logic [4:0] b_data;
  logic       b_valid, b_pe, b_s2;
  logic [1:0] b_mode;
  logic       b_tx, b_busy, b_par, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_frame_gen #(.DATA_W(8)) u_dut8 (
    .CLK(clk), .RST(rst_n), .P_DATA(a_data), .DATA_VALID(a_valid),
    .PAR_EN(a_pe), .PAR_MODE(a_mode), .STOP2(a_s2),
    .TX_OUT(a_tx), .BUSY(a_busy), .PAR_BIT(a_par), .DONE(a_done)
  );

  uart_tx_frame_gen #(.DATA_W(5)) u_dut5 (
    .CLK(clk), .RST(rst_n), .P_DATA(b_data), .DATA_VALID(b_valid),
    .PAR_EN(b_pe), .PAR_MODE(b_mode), .STOP2(b_s2),
    .TX_OUT(b_tx), .BUSY(b_busy), .PAR_BIT(b_par), .DONE(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; scrambles inputs after accept to prove isolation.
  task automatic run_frame8(input string tag, input logic [7:0] data, input logic pe,
                            input logic [1:0] mode, input logic s2,
                            input logic [31:0] exp_bits, input int len, input logic exp_par);
    a_data = data; a_pe = pe; a_mode = mode; a_s2 = s2; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = ~data; a_pe = ~pe; a_mode = ~mode; a_s2 = ~s2;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s tx[%0d]", tag, i), 32'(a_tx), 32'(exp_bits[len-1-i]));
      check($sformatf("%s busy[%0d]", tag, i), 32'(a_busy), 32'd1);
      check($sformatf("%s done[%0d]", tag, i), 32'(a_done), 32'(i == len - 1));
      if (i == 0) check($sformatf("%s par_bit", tag), 32'(a_par), 32'(exp_par));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("%s idle tx", tag), 32'(a_tx), 32'd1);
    check($sformatf("%s idle busy", tag), 32'(a_busy), 32'd0);
    check($sformatf("%s idle done", tag), 32'(a_done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_pe = 1'b0; a_mode = 2'b00; a_s2 = 1'b0;
    b_data = '0; b_valid = 1'b0; b_pe = 1'b0; b_mode = 2'b00; b_s2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst tx8", 32'(a_tx), 32'd1);
    check("rst busy8", 32'(a_busy), 32'd0);
    check("rst par8", 32'(a_par), 32'd0);
    check("rst done8", 32'(a_done), 32'd0);
    check("rst tx5", 32'(b_tx), 32'd1);
    check("rst busy5", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A5 even: 0,10100101,0,1
    run_frame8("even", 8'hA5, 1'b1, 2'b00, 1'b0, 32'b01010010101, 11, 1'b0);
    // A5 odd, two stops: 0,10100101,1,1,1
    run_frame8("odd2", 8'hA5, 1'b1, 2'b01, 1'b1, 32'b010100101111, 12, 1'b1);
    run_frame8("mark", 8'h00, 1'b1, 2'b10, 1'b0, 32'b00000000011, 11, 1'b1);
    run_frame8("space", 8'h00, 1'b1, 2'b11, 1'b0, 32'b00000000001, 11, 1'b0);
    // No parity: 0,10100101,1 and PAR_BIT still updated (even of A5 = 0)
    run_frame8("nopar", 8'hA5, 1'b0, 2'b00, 1'b0, 32'b0101001011, 10, 1'b0);

    // DATA_W=5, 5'h13, no parity: 0,1,1,0,0,1,1
    begin
      logic [6:0] exp5;
      exp5 = 7'b0110011;
      b_data = 5'h13; b_pe = 1'b0; b_mode = 2'b00; b_s2 = 1'b0; b_valid = 1'b1;
      @(posedge clk); #1;
      b_valid = 1'b0; b_data = 5'h0C; b_pe = 1'b1; b_mode = 2'b01; b_s2 = 1'b1;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        check($sformatf("dw5 tx[%0d]", i), 32'(b_tx), 32'(exp5[6-i]));
        check($sformatf("dw5 busy[%0d]", i), 32'(b_busy), 32'd1);
        check($sformatf("dw5 done[%0d]", i), 32'(b_done), 32'(i == 6));
        if (i == 0) check("dw5 par_bit", 32'(b_par), 32'd1);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("dw5 idle busy", 32'(b_busy), 32'd0);
      check("dw5 idle tx", 32'(b_tx), 32'd1);
      @(posedge clk); #1;
    end

    // Back-to-back 55 then FF, even parity, valid held through the accept slot
    begin
      logic [21:0] exp_bb;
      exp_bb = 22'b0101010100101111111101;
      a_data = 8'h55; a_pe = 1'b1; a_mode = 2'b00; a_s2 = 1'b0; a_valid = 1'b1;
      @(posedge clk); #1;
      a_data = 8'hFF;
      for (int i = 0; i < 22; i++) begin
        @(negedge clk);
        check($sformatf("b2b tx[%0d]", i), 32'(a_tx), 32'(exp_bb[21-i]));
        check($sformatf("b2b busy[%0d]", i), 32'(a_busy), 32'd1);
        check($sformatf("b2b done[%0d]", i), 32'(a_done), 32'((i == 10) || (i == 21)));
        @(posedge clk); #1;
        if (i == 10) a_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b idle busy", 32'(a_busy), 32'd0);
      @(posedge clk); #1;
    end

    // Reset during data bit 3 of an A5 odd-parity frame (PAR_BIT=1 before reset)
    a_data = 8'hA5; a_pe = 1'b1; a_mode = 2'b01; a_s2 = 1'b0; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid bit3 tx", 32'(a_tx), 32'd0);
    check("mid busy", 32'(a_busy), 32'd1);
    check("mid par", 32'(a_par), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst tx", 32'(a_tx), 32'd1);
    check("arst busy", 32'(a_busy), 32'd0);
    check("arst par", 32'(a_par), 32'd0);
    check("arst done", 32'(a_done), 32'd0);
    @(posedge clk); #1;
    check("arst hold busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame8("post_rst", 8'hA5, 1'b1, 2'b00, 1'b0, 32'b01010010101, 11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
